// File: rtl/dif_tf_power_gen.sv
// dif_tf_power_gen
//   Reads the four stage-0 DIF twiddle constants (ROM lanes tf1/tf5/tf9/tf13)
//   and streams their successive powers w_k^0 .. w_k^(len-1), mod the
//   Goldilocks prime p = 2^64 - 2^32 + 1, over a valid/ready handshake.
//
// Ports
//   clk, rst_n                 clock, async active-low reset
//   start, len, stage_counter  run request (stage 0 only), powers per lane
//   rom_cen_n                  ROM chip enable (active-low), one-cycle pulse
//   rom_tf0..rom_tf3           registered ROM outputs (tf1, tf5, tf9, tf13)
//   out_valid, out_ready       output handshake
//   out_idx                    exponent of the powers currently presented
//   tf_pow0..tf_pow3           w_k^out_idx mod p
//   busy, done                 run in progress / one-cycle completion pulse
//
// state  | meaning
// IDLE   | waiting for start (stage_counter == 0)
// REQ    | rom_cen_n low for one cycle, ROM registers its outputs
// LOAD   | capture base twiddles, seed accumulators with 1
// RUN    | present acc_k, advance on each accepted transfer
// DONE   | one-cycle done pulse, then back to IDLE

module dif_tf_power_gen #(
    parameter int P_WIDTH   = 64,
    parameter int SC_WIDTH  = 3,
    parameter int CNT_WIDTH = 10
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [CNT_WIDTH-1:0] len,
    input  logic [SC_WIDTH-1:0]  stage_counter,
    output logic                 rom_cen_n,
    input  logic [P_WIDTH-1:0]   rom_tf0,
    input  logic [P_WIDTH-1:0]   rom_tf1,
    input  logic [P_WIDTH-1:0]   rom_tf2,
    input  logic [P_WIDTH-1:0]   rom_tf3,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CNT_WIDTH-1:0] out_idx,
    output logic [P_WIDTH-1:0]   tf_pow0,
    output logic [P_WIDTH-1:0]   tf_pow1,
    output logic [P_WIDTH-1:0]   tf_pow2,
    output logic [P_WIDTH-1:0]   tf_pow3,
    output logic                 busy,
    output logic                 done
);

    localparam logic [63:0] P_MOD = 64'hFFFF_FFFF_0000_0001;
    // 2^64 mod p; adding it undoes a 2^64 wrap, subtracting it undoes a borrow.
    localparam logic [63:0] EPS   = 64'h0000_0000_FFFF_FFFF;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_LOAD,
        S_RUN,
        S_DONE
    } state_t;

    state_t state, state_nxt;

    logic [CNT_WIDTH-1:0] len_q;
    logic [P_WIDTH-1:0]   base    [4];
    logic [P_WIDTH-1:0]   acc     [4];
    logic [P_WIDTH-1:0]   acc_mul [4];
    logic [P_WIDTH-1:0]   rom_lane[4];

    logic start_ok;
    logic xfer;
    logic last_idx;

    // Goldilocks reduction of the 128-bit product x = hh:hl:lo (32/32/64):
    //   x = lo + hl*2^64 + hh*2^96 == lo + hl*(2^32-1) - hh   (mod p)
    function automatic logic [63:0] mod_mul(input logic [63:0] a, input logic [63:0] b);
        logic [127:0] prod;
        logic [63:0]  lo;
        logic [31:0]  hl;
        logic [31:0]  hh;
        logic [64:0]  diff;
        logic [63:0]  t0;
        logic [63:0]  t1;
        logic [64:0]  sum;
        logic [63:0]  r;
        prod = {64'd0, a} * {64'd0, b};
        lo   = prod[63:0];
        hl   = prod[95:64];
        hh   = prod[127:96];
        diff = {1'b0, lo} - {33'd0, hh};
        // On borrow the wrapped value is lo-hh+2^64; pulling EPS off gives lo-hh+p.
        t0   = diff[64] ? (diff[63:0] - EPS) : diff[63:0];
        t1   = {hl, 32'd0} - {32'd0, hl};
        sum  = {1'b0, t0} + {1'b0, t1};
        // t1 <= (2^32-1)^2 so the carry fix-up cannot wrap a second time.
        r    = sum[64] ? (sum[63:0] + EPS) : sum[63:0];
        if (r >= P_MOD) begin
            r = r - P_MOD;
        end
        return r;
    endfunction

    assign rom_lane[0] = rom_tf0;
    assign rom_lane[1] = rom_tf1;
    assign rom_lane[2] = rom_tf2;
    assign rom_lane[3] = rom_tf3;

    assign start_ok = start && (stage_counter == '0);
    assign xfer     = out_valid && out_ready;
    assign last_idx = (out_idx == (len_q - CNT_ONE));

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            acc_mul[k] = mod_mul(acc[k], base[k]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start_ok) begin
                    state_nxt = (len == '0) ? S_DONE : S_REQ;
                end
            end
            S_REQ:  state_nxt = S_LOAD;
            S_LOAD: state_nxt = S_RUN;
            S_RUN: begin
                if (xfer && last_idx) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rom_cen_n <= 1'b1;
            out_valid <= 1'b0;
            out_idx   <= '0;
            len_q     <= '0;
            for (int k = 0; k < 4; k++) begin
                base[k] <= '0;
                acc[k]  <= '0;
            end
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_ok && (len != '0)) begin
                        len_q     <= len;
                        rom_cen_n <= 1'b0;
                    end
                end
                S_REQ: begin
                    rom_cen_n <= 1'b1;
                end
                S_LOAD: begin
                    for (int k = 0; k < 4; k++) begin
                        base[k] <= rom_lane[k];
                        acc[k]  <= {{(P_WIDTH-1){1'b0}}, 1'b1};
                    end
                    out_idx   <= '0;
                    out_valid <= 1'b1;
                end
                S_RUN: begin
                    if (xfer) begin
                        if (last_idx) begin
                            // Powers and index stay on the last value after the run.
                            out_valid <= 1'b0;
                        end else begin
                            for (int k = 0; k < 4; k++) begin
                                acc[k] <= acc_mul[k];
                            end
                            out_idx <= out_idx + CNT_ONE;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign tf_pow0 = acc[0];
    assign tf_pow1 = acc[1];
    assign tf_pow2 = acc[2];
    assign tf_pow3 = acc[3];
    assign busy    = (state != S_IDLE);
    assign done    = (state == S_DONE);

endmodule

// File: tb/tb_dif_tf_power_gen.sv
module tb_dif_tf_power_gen;

    localparam logic [63:0] P_MOD = 64'hFFFF_FFFF_0000_0001;

    typedef struct packed {
        logic [9:0]       idx;
        logic [3:0][63:0] v;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [9:0]  len;
    logic [2:0]  stage_counter;
    logic        rom_cen_n;
    logic [63:0] rom_q [4];
    logic [63:0] rom_w [4];
    logic        out_valid;
    logic        out_ready;
    logic [9:0]  out_idx;
    logic [63:0] tf_pow0, tf_pow1, tf_pow2, tf_pow3;
    logic        busy;
    logic        done;

    int tests = 0;
    int fails = 0;

    exp_t exp_q[$];
    bit   ready_rand = 0;
    int   ecyc = 0;

    int rom_low_cnt = 0, rom_low_e = 0;
    int done_cnt = 0, done_e = 0;
    int busy_cnt = 0;
    int valid_rise_cnt = 0, valid_rise_e = 0;
    int xfer_cnt = 0, last_xfer_e = 0;

    dif_tf_power_gen #(.P_WIDTH(64), .SC_WIDTH(3), .CNT_WIDTH(10)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .len           (len),
        .stage_counter (stage_counter),
        .rom_cen_n     (rom_cen_n),
        .rom_tf0       (rom_q[0]),
        .rom_tf1       (rom_q[1]),
        .rom_tf2       (rom_q[2]),
        .rom_tf3       (rom_q[3]),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_idx       (out_idx),
        .tf_pow0       (tf_pow0),
        .tf_pow1       (tf_pow1),
        .tf_pow2       (tf_pow2),
        .tf_pow3       (tf_pow3),
        .busy          (busy),
        .done          (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) ecyc <= ecyc + 1;

    // ROM model: registers the stage-0 constants when enabled.
    always @(posedge clk) begin
        if (!rom_cen_n) begin
            for (int k = 0; k < 4; k++) rom_q[k] <= rom_w[k];
        end
    end

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = ready_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference multiply by double-and-add, independent of folding.
    function automatic logic [63:0] mulref(input logic [63:0] a, input logic [63:0] b);
        logic [64:0] r;
        r = '0;
        for (int i = 63; i >= 0; i--) begin
            r = r << 1;
            if (r >= {1'b0, P_MOD}) r = r - {1'b0, P_MOD};
            if (b[i]) begin
                r = r + {1'b0, a};
                if (r >= {1'b0, P_MOD}) r = r - {1'b0, P_MOD};
            end
        end
        return r[63:0];
    endfunction

    // Scoreboard monitor
    initial begin
        bit          prev_valid;
        bit          stall_prev;
        logic [9:0]  h_idx;
        logic [63:0] h_pow [4];
        logic [63:0] cur [4];
        exp_t        e;
        prev_valid = 0;
        stall_prev = 0;
        forever begin
            @(negedge clk);
            cur[0] = tf_pow0; cur[1] = tf_pow1; cur[2] = tf_pow2; cur[3] = tf_pow3;
            if (!rom_cen_n) begin rom_low_cnt++; rom_low_e = ecyc; end
            if (done) begin done_cnt++; done_e = ecyc; end
            if (busy) busy_cnt++;
            if (out_valid && !prev_valid) begin valid_rise_cnt++; valid_rise_e = ecyc; end
            if (stall_prev) begin
                check("stall_valid", 64'(out_valid), 64'd1);
                check("stall_idx", 64'(out_idx), 64'(h_idx));
                for (int k = 0; k < 4; k++) check($sformatf("stall_pow%0d", k), cur[k], h_pow[k]);
            end
            if (out_valid && out_ready) begin
                xfer_cnt++;
                last_xfer_e = ecyc;
                check("sb_nonempty", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("sb_idx", 64'(out_idx), 64'(e.idx));
                    for (int k = 0; k < 4; k++)
                        check($sformatf("sb_pow%0d_idx%0d", k, e.idx), cur[k], e.v[k]);
                end
            end
            stall_prev = out_valid && !out_ready;
            h_idx = out_idx;
            for (int k = 0; k < 4; k++) h_pow[k] = cur[k];
            prev_valid = out_valid;
        end
    end

    task automatic push_expected(input int n);
        logic [63:0] a [4];
        exp_t e;
        for (int k = 0; k < 4; k++) a[k] = 64'd1;
        for (int i = 0; i < n; i++) begin
            e.idx = 10'(i);
            for (int k = 0; k < 4; k++) begin
                e.v[k] = a[k];
                a[k] = mulref(a[k], rom_w[k]);
            end
            exp_q.push_back(e);
        end
    endtask

    task automatic run(input int n, input logic [2:0] sc, input bit rnd, input bit poke);
        int  rl0, d0, b0, v0, x0, e0;
        bit  ignored, expect_done, got;
        ignored     = (sc != 3'd0);
        expect_done = !ignored;
        rl0 = rom_low_cnt; d0 = done_cnt; b0 = busy_cnt; v0 = valid_rise_cnt; x0 = xfer_cnt;
        if (!ignored) push_expected(n);
        ready_rand = rnd;
        @(posedge clk); #1;
        start = 1'b1; len = 10'(n); stage_counter = sc;
        @(posedge clk); #1;
        start = 1'b0;
        e0 = ecyc;
        got = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk); #1;
            if (poke && i == 3) begin start = 1'b1; len = 10'd2; end
            if (poke && i == 4) begin start = 1'b0; stage_counter = 3'd2; end
            if (expect_done && done_cnt > d0) begin got = 1; break; end
            if (!expect_done && i == 12) break;
        end
        ready_rand = 0;
        if (expect_done) begin
            check("done_seen", 64'(got), 64'd1);
            check("done_once", 64'(done_cnt - d0), 64'd1);
            @(negedge clk); #1;
            check("idle_after_done", 64'(busy), 64'd0);
            check("done_one_cycle", 64'(done_cnt - d0), 64'd1);
            check("xfer_count", 64'(xfer_cnt - x0), 64'(n));
            check("sb_drained", 64'(exp_q.size()), 64'd0);
            if (n == 0) begin
                check("len0_rom_idle", 64'(rom_low_cnt - rl0), 64'd0);
                check("len0_no_valid", 64'(valid_rise_cnt - v0), 64'd0);
                check("len0_done_time", 64'(done_e), 64'(e0));
            end else begin
                check("rom_pulse_cycles", 64'(rom_low_cnt - rl0), 64'd1);
                check("rom_pulse_time", 64'(rom_low_e), 64'(e0));
                check("valid_once", 64'(valid_rise_cnt - v0), 64'd1);
                check("first_valid_time", 64'(valid_rise_e), 64'(e0 + 2));
                check("done_after_last", 64'(done_e), 64'(last_xfer_e + 1));
            end
        end else begin
            check("ign_rom", 64'(rom_low_cnt - rl0), 64'd0);
            check("ign_busy", 64'(busy_cnt - b0), 64'd0);
            check("ign_valid", 64'(valid_rise_cnt - v0), 64'd0);
            check("ign_done", 64'(done_cnt - d0), 64'd0);
        end
    endtask

    task automatic set_const_rom();
        rom_w[0] = 64'h381d997f2d35d682;
        rom_w[1] = 64'h252502e45f699196;
        rom_w[2] = 64'h4a3f9ccc62d9a86a;
        rom_w[3] = 64'h75c91fcd00f90ea6;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rom_cen_n"}, 64'(rom_cen_n), 64'd1);
        check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        check({tag, "_out_idx"},   64'(out_idx),   64'd0);
        check({tag, "_pow0"}, tf_pow0, 64'd0);
        check({tag, "_pow1"}, tf_pow1, 64'd0);
        check({tag, "_pow2"}, tf_pow2, 64'd0);
        check({tag, "_pow3"}, tf_pow3, 64'd0);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_done"}, 64'(done), 64'd0);
    endtask

    initial begin
        int  d0;
        bit  hit;
        rst_n = 1'b0;
        start = 1'b0;
        len = '0;
        stage_counter = '0;
        set_const_rom();
        repeat (3) @(posedge clk);
        #2;
        check_reset_outputs("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Nominal run, then same with stalls.
        run(4, 3'd0, 1'b0, 1'b0);
        check("base_w1_is_const", mulref(64'd1, rom_w[1]), 64'h252502e45f699196);
        run(4, 3'd0, 1'b1, 1'b0);

        // Non-zero stage: start ignored.
        run(4, 3'd2, 1'b0, 1'b0);

        // len == 0
        run(0, 3'd0, 1'b0, 1'b0);

        // Restart attempt and stage change during an 8-long run.
        run(8, 3'd0, 1'b0, 1'b1);

        // Multiply corners: p-1 alternates, 0 collapses, 1 stays, 2 doubles.
        rom_w[0] = P_MOD - 64'd1;
        rom_w[1] = 64'd0;
        rom_w[2] = 64'd1;
        rom_w[3] = 64'd2;
        run(4, 3'd0, 1'b0, 1'b0);
        check("tf_pow0_last_p_minus_1", tf_pow0, 64'hFFFF_FFFF_0000_0000);
        check("tf_pow1_last_zero", tf_pow1, 64'd0);
        check("tf_pow3_last_eight", tf_pow3, 64'd8);
        check("out_idx_held", 64'(out_idx), 64'd3);

        // Reset in the middle of a run.
        set_const_rom();
        d0 = done_cnt;
        push_expected(8);
        @(posedge clk); #1;
        start = 1'b1; len = 10'd8; stage_counter = 3'd0;
        @(posedge clk); #1;
        start = 1'b0;
        hit = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk); #1;
            if (out_valid && out_idx == 10'd3) begin hit = 1; break; end
        end
        check("reach_idx3", 64'(hit), 64'd1);
        #1;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midrun_reset");
        exp_q.delete();
        repeat (3) @(negedge clk);
        #1;
        check("no_done_after_reset", 64'(done_cnt - d0), 64'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        run(3, 3'd0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
